// File: rtl/sha256_msg_padder.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_msg_padder
//  Purpose  : Streaming SHA-256 message pre-processor. Accepts a byte message
//             as IN_W-bit beats and emits padded 512-bit blocks: the data,
//             a single 0x80 byte, zero fill and the 64-bit big-endian message
//             bit-length in the last 8 bytes of the final block.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1              clock, rising edge
//    rst        in   1              asynchronous, active-low reset
//    in_data    in   IN_W           message bytes, first byte in the top byte
//    in_valid   in   1              beat valid
//    in_last    in   1              final beat of the message
//    in_bytes   in   clog2(IN_W/8)+1 valid bytes on the last beat (MSB aligned)
//    in_ready   out  1              padder can accept a beat
//    blk_data   out  512            padded block, byte 0 at [511:504]
//    blk_valid  out  1              block valid
//    blk_ready  in   1              consumer accepts block
//    blk_first  out  1              first block of the message
//    blk_last   out  1              last block of the message
//    overflow   out  1              sticky: bit-length counter wrapped
// ============================================================================
module sha256_msg_padder #(
    parameter int IN_W  = 32,
    parameter int LEN_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic [$clog2(IN_W/8):0]  in_bytes,
    output logic                     in_ready,
    output logic [511:0]             blk_data,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    output logic                     blk_first,
    output logic                     blk_last,
    output logic                     overflow
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int         BPB       = IN_W / 8;       // bytes per beat
    localparam int         CNT_W     = LEN_W + 11;     // count + carry room for 8*512
    localparam logic [7:0] BPB_B     = 8'(BPB);
    localparam logic [7:0] BLK_BYTES = 8'd64;
    // Last byte index after which 0x80 plus the 8 length bytes still fit.
    localparam logic [7:0] LAST_FIT  = 8'd55;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FILL       = 3'd1,
        S_EMIT       = 3'd2,
        S_EMIT_PAD   = 3'd3,
        S_PAD_BLK    = 3'd4,
        S_EMIT_FINAL = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state;
    logic [7:0]        ptr;          // next free byte in the block (beat aligned)
    logic [LEN_W-1:0]  bit_cnt;      // message bit length so far
    logic              first_pend;   // first block of this message not yet emitted
    logic              pad80_pend;   // data ended on a block boundary: 0x80 goes to next block

    // ------------------------------------------------------------------------
    // Beat-processing datapath
    // ------------------------------------------------------------------------
    logic              accept;
    logic [7:0]        n_bytes;
    logic [7:0]        end_ptr;
    logic [CNT_W-1:0]  cnt_sum;
    logic [LEN_W-1:0]  cnt_next;
    logic              cnt_wrap;
    logic              fits;
    logic              blk_full;
    logic              first_now;
    logic [63:0]       len_next;
    logic [63:0]       len_cur;
    logic [511:0]      beat_blk;

    assign accept    = in_valid && in_ready;
    assign first_now = (state == S_IDLE) || first_pend;

    // Bytes carried by this beat; an out-of-range in_bytes is clamped.
    always_comb begin
        n_bytes = BPB_B;
        if (in_last) begin
            n_bytes = (8'(in_bytes) > BPB_B) ? BPB_B : 8'(in_bytes);
        end
    end

    assign end_ptr  = ptr + n_bytes;
    assign fits     = (end_ptr <= LAST_FIT);
    assign blk_full = (end_ptr == BLK_BYTES);

    // Bit counter with carry detection; the carry bits flag a wrap.
    assign cnt_sum  = {11'b0, bit_cnt} + {{LEN_W{1'b0}}, n_bytes, 3'b000};
    assign cnt_next = cnt_sum[LEN_W-1:0];
    assign cnt_wrap = |cnt_sum[CNT_W-1:LEN_W];

    // Length fields are zero-extended into the 64-bit slot.
    always_comb begin
        len_next               = '0;
        len_next[LEN_W-1:0]    = cnt_next;
        len_cur                = '0;
        len_cur[LEN_W-1:0]     = bit_cnt;
    end

    // Merge the incoming beat into the block under construction. Bytes below
    // ptr are kept. On the last beat everything from the data end onward is
    // rewritten: 0x80 right after the data, zeros after that, and the length
    // in the tail when it fits in this block.
    always_comb begin
        beat_blk = blk_data;
        for (int i = 0; i < 64; i++) begin
            if (8'(i) >= ptr) begin
                if (8'(i) < end_ptr) begin
                    beat_blk[511-8*i -: 8] = in_data[IN_W-1-8*(i%BPB) -: 8];
                end else if (in_last && (8'(i) == end_ptr)) begin
                    beat_blk[511-8*i -: 8] = 8'h80;
                end else if (in_last) begin
                    beat_blk[511-8*i -: 8] = 8'h00;
                end
            end
        end
        if (in_last && fits) begin
            beat_blk[63:0] = len_next;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            bit_cnt    <= '0;
            first_pend <= 1'b0;
            pad80_pend <= 1'b0;
            in_ready   <= 1'b0;
            blk_data   <= '0;
            blk_valid  <= 1'b0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_FILL: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        blk_data <= beat_blk;
                        bit_cnt  <= cnt_next;
                        // A new message starts with a clean overflow flag.
                        overflow <= (state == S_IDLE) ? cnt_wrap : (overflow | cnt_wrap);
                        if (in_last) begin
                            ptr        <= '0;
                            in_ready   <= 1'b0;
                            blk_valid  <= 1'b1;
                            blk_first  <= first_now;
                            first_pend <= 1'b0;
                            if (fits) begin
                                blk_last <= 1'b1;
                                state    <= S_EMIT_FINAL;
                            end else begin
                                pad80_pend <= blk_full;
                                state      <= S_EMIT_PAD;
                            end
                        end else if (blk_full) begin
                            ptr        <= '0;
                            in_ready   <= 1'b0;
                            blk_valid  <= 1'b1;
                            blk_first  <= first_now;
                            first_pend <= 1'b0;
                            state      <= S_EMIT;
                        end else begin
                            ptr        <= end_ptr;
                            first_pend <= first_now;
                            state      <= S_FILL;
                        end
                    end
                end

                S_EMIT: begin
                    if (blk_valid && blk_ready) begin
                        blk_valid <= 1'b0;
                        blk_first <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_FILL;
                    end
                end

                S_EMIT_PAD: begin
                    if (blk_valid && blk_ready) begin
                        blk_valid <= 1'b0;
                        blk_first <= 1'b0;
                        state     <= S_PAD_BLK;
                    end
                end

                // Extra block holding only (optional 0x80,) zeros and length.
                S_PAD_BLK: begin
                    blk_data   <= {(pad80_pend ? 8'h80 : 8'h00), 440'd0, len_cur};
                    pad80_pend <= 1'b0;
                    blk_valid  <= 1'b1;
                    blk_last   <= 1'b1;
                    state      <= S_EMIT_FINAL;
                end

                S_EMIT_FINAL: begin
                    if (blk_valid && blk_ready) begin
                        blk_valid <= 1'b0;
                        blk_first <= 1'b0;
                        blk_last  <= 1'b0;
                        in_ready  <= 1'b1;
                        ptr       <= '0;
                        bit_cnt   <= '0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b0;
                    blk_valid <= 1'b0;
                    blk_first <= 1'b0;
                    blk_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_padder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_msg_padder
//  Purpose  : Self-checking bench for sha256_msg_padder. Two instances:
//             IN_W=32/LEN_W=64 (random and boundary messages, back-pressure)
//             and IN_W=8/LEN_W=8 ("abc", counter wrap, reset abort).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sha256_msg_padder;

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
        logic         ovf;
    } exp_t;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] EMPTY_BLK = {8'h80, 504'h0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    exp_t       q1[$];
    exp_t       q2[$];
    exp_t       pinq[$];
    bit [7:0]   msg[$];

    // ---------------- instance 1: IN_W=32, LEN_W=64 ----------------
    logic         rst1, v1, l1, rdy1, bv1, br1, bf1, bl1, ov1;
    logic [31:0]  d1;
    logic [2:0]   b1;
    logic [511:0] bd1;
    bit           hold1 = 1'b0;
    bit           rand_ready1 = 1'b1;

    sha256_msg_padder #(.IN_W(32), .LEN_W(64)) dut1 (
        .clk(clk), .rst(rst1), .in_data(d1), .in_valid(v1), .in_last(l1),
        .in_bytes(b1), .in_ready(rdy1), .blk_data(bd1), .blk_valid(bv1),
        .blk_ready(br1), .blk_first(bf1), .blk_last(bl1), .overflow(ov1)
    );

    // ---------------- instance 2: IN_W=8, LEN_W=8 ----------------
    logic         rst2, v2, l2, rdy2, bv2, br2, bf2, bl2, ov2;
    logic [7:0]   d2;
    logic [0:0]   b2;
    logic [511:0] bd2;

    sha256_msg_padder #(.IN_W(8), .LEN_W(8)) dut2 (
        .clk(clk), .rst(rst2), .in_data(d2), .in_valid(v2), .in_last(l2),
        .in_bytes(b2), .in_ready(rdy2), .blk_data(bd2), .blk_valid(bv2),
        .blk_ready(br2), .blk_first(bf2), .blk_last(bl2), .overflow(ov2)
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    // Reference model: message ++ 0x80 ++ zeros until 56 mod 64 ++ 64-bit
    // big-endian bit length (mod 2^lenw), then cut into 64-byte blocks.
    function automatic void model_blocks(input int which, input int lenw);
        bit [7:0]        p[$];
        longint unsigned bits;
        longint unsigned done_bits;
        bit [63:0]       len;
        exp_t            e;
        int              nblk;
        int              upto;
        p    = msg;
        bits = longint'(msg.size()) * 8;
        len  = (lenw >= 64) ? bits : (bits & ((64'd1 << lenw) - 64'd1));
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(len[8*k +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            e.data = '0;
            for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = p[64*b+j];
            e.first   = (b == 0);
            e.last    = (b == nblk - 1);
            upto      = (msg.size() < 64*(b+1)) ? msg.size() : 64*(b+1);
            done_bits = longint'(upto) * 8;
            e.ovf     = (lenw < 64) && (done_bits >= (64'd1 << lenw));
            case (which)
                1:       q1.push_back(e);
                2:       q2.push_back(e);
                default: pinq.push_back(e);
            endcase
        end
    endfunction

    // ---------------- consumer ready ----------------
    always @(posedge clk) begin
        #1;
        br1 = hold1 ? 1'b0 : (rand_ready1 ? ($urandom_range(3) != 0) : 1'b1);
        br2 = ($urandom_range(3) != 0);
    end

    // ---------------- compare processes ----------------
    logic [511:0] pd1, pd2;
    logic         pv1 = 1'b0, pr1 = 1'b0, pf1 = 1'b0, pl1 = 1'b0;
    logic         pv2 = 1'b0, pr2 = 1'b0, pf2 = 1'b0, pl2 = 1'b0;
    exp_t         e1, e2;

    always @(negedge clk) begin
        if (rst1 === 1'b1) begin
            if (pv1 && !pr1) begin
                chkb("hold_valid1", bv1, 1'b1);
                chk ("hold_data1",  bd1, pd1);
                chkb("hold_first1", bf1, pf1);
                chkb("hold_last1",  bl1, pl1);
            end
            if (bv1) chkb("in_ready_during_emit1", rdy1, 1'b0);
            if (bv1 && br1) begin
                if (q1.size() == 0) begin
                    fail_now("unexpected_block1");
                end else begin
                    e1 = q1.pop_front();
                    chk ("blk_data1",  bd1, e1.data);
                    chkb("blk_first1", bf1, e1.first);
                    chkb("blk_last1",  bl1, e1.last);
                    chkb("overflow1",  ov1, e1.ovf);
                end
            end
            pv1 = bv1; pr1 = br1; pd1 = bd1; pf1 = bf1; pl1 = bl1;
        end else begin
            pv1 = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst2 === 1'b1) begin
            if (pv2 && !pr2) begin
                chkb("hold_valid2", bv2, 1'b1);
                chk ("hold_data2",  bd2, pd2);
                chkb("hold_first2", bf2, pf2);
                chkb("hold_last2",  bl2, pl2);
            end
            if (bv2) chkb("in_ready_during_emit2", rdy2, 1'b0);
            if (bv2 && br2) begin
                if (q2.size() == 0) begin
                    fail_now("unexpected_block2");
                end else begin
                    e2 = q2.pop_front();
                    chk ("blk_data2",  bd2, e2.data);
                    chkb("blk_first2", bf2, e2.first);
                    chkb("blk_last2",  bl2, e2.last);
                    chkb("overflow2",  ov2, e2.ovf);
                end
            end
            pv2 = bv2; pr2 = br2; pd2 = bd2; pf2 = bf2; pl2 = bl2;
        end else begin
            pv2 = 1'b0;
        end
    end

    // ---------------- drivers (enter and leave at posedge+1) ----------------
    task automatic wait_accept1();
        int t   = 0;
        bit got = 1'b0;
        while (!got && t < 2000) begin
            @(negedge clk); got = rdy1;
            @(posedge clk); #1; t++;
        end
        if (!got) fail_now("accept_timeout1");
    endtask

    task automatic wait_accept2();
        int t   = 0;
        bit got = 1'b0;
        while (!got && t < 2000) begin
            @(negedge clk); got = rdy2;
            @(posedge clk); #1; t++;
        end
        if (!got) fail_now("accept_timeout2");
    endtask

    // Random message of len bytes on instance 1. extra_empty closes a
    // multiple-of-4 message with a separate in_bytes=0 beat.
    task automatic send1(input int len, input bit extra_empty, input bit gaps);
        int          nbeats;
        int          pos;
        int          nb;
        logic [31:0] w;
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
        model_blocks(1, 64);
        if (len > 0 && (len % 4) == 0 && extra_empty) nbeats = len / 4 + 1;
        else nbeats = (len == 0) ? 1 : (len + 3) / 4;
        pos = 0;
        for (int k = 0; k < nbeats; k++) begin
            w  = $urandom;
            nb = (len - pos > 4) ? 4 : (len - pos);
            for (int j = 0; j < nb; j++) w[31-8*j -: 8] = msg[pos+j];
            if (gaps) begin
                repeat ($urandom_range(2)) begin v1 = 1'b0; @(posedge clk); #1; end
            end
            d1 = w;
            v1 = 1'b1;
            l1 = (k == nbeats - 1);
            b1 = l1 ? 3'(nb) : 3'($urandom);
            wait_accept1();
            pos += nb;
        end
        v1 = 1'b0;
        l1 = 1'b0;
    endtask

    // Sends msg on instance 2; abort_at >= 0 stops after that many beats
    // and records no expectation.
    task automatic send2(input int abort_at);
        int nbeats;
        nbeats = (msg.size() == 0) ? 1 : msg.size();
        if (abort_at < 0) model_blocks(2, 8);
        for (int k = 0; k < nbeats; k++) begin
            if (abort_at >= 0 && k == abort_at) break;
            d2 = (msg.size() == 0) ? 8'($urandom) : msg[k];
            b2 = (msg.size() == 0) ? 1'b0 : 1'b1;
            l2 = (k == nbeats - 1);
            v2 = 1'b1;
            wait_accept2();
        end
        v2 = 1'b0;
        l2 = 1'b0;
    endtask

    task automatic bp_check();
        int           t = 0;
        logic [511:0] cap;
        do begin @(negedge clk); t++; end while (!bv1 && t < 500);
        if (!bv1) begin
            fail_now("bp_wait_valid");
        end else begin
            cap = bd1;
            for (int k = 0; k < 5; k++) begin
                if (k > 0) @(negedge clk);
                chkb("bp_valid",    bv1,  1'b1);
                chk ("bp_data",     bd1,  cap);
                chkb("bp_in_ready", rdy1, 1'b0);
            end
            hold1 = 1'b0;
            @(posedge clk); @(posedge clk); @(negedge clk);
            chkb("bp_in_ready_after", rdy1, 1'b1);
            chkb("bp_valid_after",    bv1,  1'b0);
        end
    endtask

    task automatic drain(input int which);
        int t = 0;
        while (((which == 1) ? q1.size() : q2.size()) != 0 && t < 3000) begin
            @(negedge clk); t++;
        end
        chk(which == 1 ? "drain1" : "drain2", 512'((which == 1) ? q1.size() : q2.size()), 512'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    exp_t pe;
    int   edge_len[7] = '{55, 56, 63, 64, 119, 120, 128};
    int   len;

    initial begin
        rst1 = 1'b0; v1 = 1'b0; l1 = 1'b0; d1 = '0; b1 = '0; br1 = 1'b0;
        rst2 = 1'b0; v2 = 1'b0; l2 = 1'b0; d2 = '0; b2 = '0; br2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset values
        chkb("rst_valid1", bv1, 1'b0);  chkb("rst_ready1", rdy1, 1'b0);
        chkb("rst_first1", bf1, 1'b0);  chkb("rst_last1",  bl1,  1'b0);
        chkb("rst_ovf1",   ov1, 1'b0);  chk ("rst_data1",  bd1,  512'd0);
        chkb("rst_valid2", bv2, 1'b0);  chkb("rst_ready2", rdy2, 1'b0);
        chkb("rst_ovf2",   ov2, 1'b0);  chk ("rst_data2",  bd2,  512'd0);

        // Pin the model with hand-computed blocks
        msg = '{8'h61, 8'h62, 8'h63};
        model_blocks(0, 64);
        pe = pinq.pop_front();
        chk ("pin_abc", pe.data, ABC_BLK);
        chkb("pin_abc_fl", pe.first & pe.last, 1'b1);
        msg.delete();
        model_blocks(0, 64);
        pe = pinq.pop_front();
        chk ("pin_empty", pe.data, EMPTY_BLK);
        msg.delete();
        for (int i = 0; i < 55; i++) msg.push_back(8'h11);
        model_blocks(0, 64);
        pe = pinq.pop_front();
        chk ("pin_55_len", 512'(pe.data[63:0]), 512'h1B8);
        chk ("pin_55_pad", 512'(pe.data[511-8*55 -: 8]), 512'h80);
        msg.push_back(8'h11);
        model_blocks(0, 64);
        chk ("pin_56_count", 512'(pinq.size()), 512'd2);
        pe = pinq.pop_back();
        chk ("pin_56_blk2", pe.data, {448'h0, 64'h1C0});
        pinq.delete();

        // Release reset; in_ready follows one clock later
        @(posedge clk); #1;
        rst1 = 1'b1; rst2 = 1'b1;
        @(negedge clk);
        chkb("ready_before_clk1", rdy1, 1'b0);
        @(negedge clk);
        chkb("ready_after_clk1", rdy1, 1'b1);
        chkb("ready_after_clk2", rdy2, 1'b1);
        @(posedge clk); #1;

        // Directed boundary messages on instance 1
        send1(0,  1'b0, 1'b0);
        send1(55, 1'b0, 1'b0);
        send1(56, 1'b0, 1'b0);
        send1(64, 1'b0, 1'b0);
        send1(64, 1'b1, 1'b0);
        drain(1);

        // Back-pressure: block held for 5 cycles while the next beat waits
        rand_ready1 = 1'b0;
        hold1       = 1'b1;
        fork
            send1(68, 1'b0, 1'b0);
            bp_check();
        join
        hold1       = 1'b0;
        rand_ready1 = 1'b1;
        drain(1);

        // Random messages, biased toward block boundaries
        for (int m = 0; m < 30; m++) begin
            len = ($urandom_range(2) == 0) ? edge_len[$urandom_range(6)] : int'($urandom_range(140));
            send1(len, 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        drain(1);

        // Instance 2: "abc", then a 32-byte message that wraps the counter
        msg = '{8'h61, 8'h62, 8'h63};
        send2(-1);
        msg.delete();
        for (int i = 0; i < 32; i++) msg.push_back(8'($urandom));
        send2(-1);
        drain(2);

        // Abort a second wrapping message with reset
        msg.delete();
        for (int i = 0; i < 40; i++) msg.push_back(8'($urandom));
        send2(35);
        @(negedge clk);
        chkb("ovf_before_abort2", ov2, 1'b1);
        #2 rst2 = 1'b0;
        #1;
        chkb("abort_valid2", bv2,  1'b0);
        chkb("abort_ovf2",   ov2,  1'b0);
        chkb("abort_ready2", rdy2, 1'b0);
        chk ("abort_data2",  bd2,  512'd0);
        @(posedge clk); #1;
        rst2 = 1'b1;
        msg = '{8'h61, 8'h62, 8'h63};
        send2(-1);
        drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
